// File: rtl/fetch_if.sv
// Fetch unit bus bundle: memory request/response channel, instruction output
// channel and core redirect.
interface fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
               redirect_valid, redirect_pc
    );

    modport master (
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order memory requests feeding a
// small instruction FIFO, with redirect flush and stale-response discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic   clk,
    input logic   reset,
    fetch_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt, r_infl, r_disc;
    logic [31:0]   r_fetch_pc, r_resp_pc;

    logic          w_credit, w_req_fire, w_resp_acc, w_push, w_pop;
    logic [31:0]   w_redir_pc;
    logic          w_unused;

    // Queue entries plus outstanding requests must fit in the queue, so a
    // returning response always has a slot.
    assign w_credit   = ({1'b0, r_cnt} + {1'b0, r_infl}) < (CW+1)'(DEPTH);
    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused   = &{1'b0, bus.redirect_pc[1:0]};

    assign bus.mem_req_valid = !reset && !bus.redirect_valid && w_credit;
    assign bus.mem_req_addr  = r_fetch_pc;
    assign bus.out_valid     = !reset && (r_cnt != '0);
    assign bus.out_instr     = reset ? 32'h0 : r_instr[r_rd];
    assign bus.out_pc        = reset ? 32'h0 : r_pc[r_rd];

    assign w_req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign w_resp_acc = bus.mem_resp_valid && (r_infl != '0);
    assign w_push     = !reset && w_resp_acc && (r_disc == '0) && !bus.redirect_valid;
    assign w_pop      = bus.out_valid && bus.out_ready && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr] <= bus.mem_resp_data;
            r_pc[r_wr]    <= r_resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
            r_infl     <= '0;
            r_disc     <= '0;
            r_fetch_pc <= {RESET_PC[31:2], 2'b00};
            r_resp_pc  <= {RESET_PC[31:2], 2'b00};
        end else begin
            r_infl <= r_infl + CW'(w_req_fire) - CW'(w_resp_acc);
            if (bus.redirect_valid) begin
                // Everything still outstanding belongs to the old path.
                r_cnt      <= '0;
                r_wr       <= r_rd;
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_disc     <= r_infl - CW'(w_resp_acc);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) begin
                    r_wr      <= r_wr + AW'(1);
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) r_rd <= r_rd + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
                if (w_resp_acc && (r_disc != '0)) r_disc <= r_disc - CW'(1);
            end
        end
    end
endmodule
